sub_shift_seq: RTL and testbench
================================

Name: sub_shift_seq

Overview:
- Sequential AES SubBytes + ShiftRows stage. Sits directly upstream of the MixColumns stage and drives its 128-bit state input.
- Substitutes one 32-bit column per cycle through four FIPS-197 S-box lookups, which are constant tables inside this block.
- Presents the ShiftRows-permuted result behind a valid/ready handshake.
- A side-band tag (round number or last-round flag) travels alongside the state unchanged.

Parameters:
- TAG_W, 4, width of the pass-through tag accompanying each state.

Ports:
- clk  in  1  single clock; all flops on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data/in_tag valid
- in_ready  out  1  block can accept a state this cycle
- in_data  in  128  state; [127:96]=column 0 … [31:0]=column 3; within a column, the MS byte is row 0
- in_tag  in  TAG_W  side-band, passed through unchanged
- out_valid  out  1  out_data/out_tag valid
- out_ready  in  1  downstream accepts
- out_data  out  128  ShiftRows(SubBytes(in_data)), same byte ordering as in_data
- out_tag  out  TAG_W  tag captured with the state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cnt=0, buf=0, tag_q=0.
  - out_valid=0, in_ready=1, out_data=ShiftRows(0)=0, out_tag=0.
- States:
  - IDLE
  - SUB: cnt 0..3
  - DONE
- Acceptance: a state is accepted when in_valid & in_ready at a rising edge. buf<=in_data, tag_q<=in_tag, cnt<=0, next state SUB.
- SUB processing:
  - Each edge in SUB replaces column cnt of buf with its byte-wise S-box image; the other columns are held.
  - Column cnt=0 is buf[127:96], cnt=3 is buf[31:0].
  - cnt increments; on the edge where cnt==3, go to DONE.
- DONE outputs:
  - out_valid=1.
  - out_data = ShiftRows(buf): row r is rotated left by r byte positions across columns. Out byte (row r, col c) = buf byte (row r, col (c+r) mod 4).
  - out_data is pure wiring from buf and is stable throughout DONE.
  - out_tag=tag_q.
- Latency: out_valid rises 4 cycles after the acceptance edge, i.e. after 4 SUB edges.
- Output handshake: out_valid & out_ready at an edge completes the transfer.
  - Leave DONE for IDLE when in_valid=0.
  - Go straight to SUB when in_valid=1 (see in_ready).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Back-to-back throughput is one state per 5 cycles.
  - in_ready is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- Output stability: while out_valid=1 and out_ready=0, out_data/out_tag are held constant and no new input is accepted (backpressure is unbounded).
- Simultaneous out handshake + new input: the new in_data is loaded into buf on the same edge the old result leaves. The old result must be the value sampled downstream on that edge.
- in_valid deasserted or in_data changed while in SUB or DONE: ignored; only the accepted value is processed.
- rst_n asserted mid-SUB or in DONE: the in-flight state is discarded immediately and out_valid drops asynchronously. After release, the block returns to IDLE with in_ready=1.
- S-box: full 256-entry FIPS-197 forward table. Four instances are evaluated in parallel on the selected column. No inverse cipher support.

Test Plan:
- Single state (FIPS-197 App. B, round 1 input):
  - Stimulus: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_tag=1, out_ready=1.
  - Required: out_valid high exactly 4 cycles after acceptance; out_data=d4bf5d30e0b452aeb84111f11e2798e5; out_tag=1.
  - Feeding this out_data into MixColumns gives 046681e5e0cb199a48f8d37a2806264c.
- All-zero input:
  - Stimulus: in_data=0.
  - Required: out_data=6363…63 (all 16 bytes 0x63). in_ready=0 throughout SUB.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises; in_valid held high with a second state.
  - Required: out_data/out_tag constant, in_ready=0, second state not taken. Once out_ready=1, transfer and second acceptance occur on the same edge.
- Back-to-back:
  - Stimulus: three states with in_valid and out_ready held high.
  - Required: outputs in order, spaced 5 cycles apart, each matching the reference model.
- Input noise:
  - Stimulus: change in_data every cycle during SUB.
  - Required: output equals the transform of the originally accepted value.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously at SUB cnt=2, then release.
  - Required: out_valid=0 and out_tag=0 immediately; in_ready=1 after release; the next state is processed correctly with latency 4.

Source files
------------

// File: rtl/sub_shift_seq.sv
// sub_shift_seq: sequential AES SubBytes + ShiftRows stage.
// One 32-bit column is pushed through four forward S-boxes per cycle; after
// four columns the ShiftRows view of the buffer is offered downstream behind
// a valid/ready handshake, with a side-band tag carried alongside unchanged.
module sub_shift_seq #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {x, 3'b000};
    return SBOX[11'd2047 - idx -: 8];
  endfunction

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic [127:0]      sbuf;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;
  logic [31:0]       col_sel;
  logic [31:0]       col_sub;

  // Handshake: ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (state == DONE);
    out_tag   = tag_q;
  end

  // Column selected by cnt and its byte-wise S-box image.
  always_comb begin
    col_sel = sbuf[127:96];
    case (cnt)
      2'd0: col_sel = sbuf[127:96];
      2'd1: col_sel = sbuf[95:64];
      2'd2: col_sel = sbuf[63:32];
      2'd3: col_sel = sbuf[31:0];
      default: col_sel = sbuf[127:96];
    endcase
    col_sub = {sbox(col_sel[31:24]), sbox(col_sel[23:16]),
               sbox(col_sel[15:8]),  sbox(col_sel[7:0])};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SUB;
      SUB:  if (cnt == 2'd3) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? SUB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Working buffer: load on acceptance, substitute one column per SUB edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf  <= '0;
      tag_q <= '0;
      cnt   <= 2'd0;
    end else if (accept) begin
      sbuf  <= in_data;
      tag_q <= in_tag;
      cnt   <= 2'd0;
    end else if (state == SUB) begin
      case (cnt)
        2'd0: sbuf[127:96] <= col_sub;
        2'd1: sbuf[95:64]  <= col_sub;
        2'd2: sbuf[63:32]  <= col_sub;
        2'd3: sbuf[31:0]   <= col_sub;
        default: sbuf[127:96] <= col_sub;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

  // ShiftRows wiring: out (row r, col c) = buf (row r, col (c+r) mod 4).
  always_comb begin
    out_data = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        out_data[127-32*c-8*r -: 8] = sbuf[127-32*((c+r)%4)-8*r -: 8];
      end
    end
  end

endmodule

// File: tb/tb_sub_shift_seq.sv
// tb_sub_shift_seq: directed scoreboard bench for sub_shift_seq.
// The driver pushes expected results when a state is accepted; a monitor
// pops and compares on every output handshake and checks the 4-cycle latency.
module tb_sub_shift_seq;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [127:0]     in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0]     d;
    logic [TAG_W-1:0] t;
    int               acc;
  } exp_t;
  exp_t sb[$];

  sub_shift_seq #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  // Reference: state as a 4x4 byte matrix st[row][col], substitute, then rotate rows.
  function automatic logic [127:0] ref_ss(input logic [127:0] d);
    logic [7:0] st [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = sbox_tab[d[127-32*c-8*r -: 8]];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = st[r][(c+r)%4];
    return o;
  endfunction

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive a state (called at a falling edge) and hold it until accepted.
  task automatic send(input logic [127:0] d, input logic [TAG_W-1:0] t,
                      input logic [127:0] expd, output int acc);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    #1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_int("accept_timeout", int'(in_ready), 1);
    acc   = cyc + 1;
    e.d   = expd;
    e.t   = t;
    e.acc = acc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk_int("drain_pending", sb.size(), 0);
  endtask

  // Monitor: latency on the rising out_valid, data/tag on each handshake.
  bit seen_rise = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          if (!seen_rise) begin
            chk_int("latency", cyc - sb[0].acc, 4);
            seen_rise = 1'b1;
          end
          if (out_ready) begin
            chk128("out_data", out_data, sb[0].d);
            chk_int("out_tag", int'(out_tag), int'(sb[0].t));
            void'(sb.pop_front());
            seen_rise = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    logic [127:0] va, vb, vc, ea;

    // Reset state.
    #1;
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk128("rst_out_data", out_data, '0);
    chk_int("rst_out_tag", int'(out_tag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 Appendix B round 1.
    out_ready = 1'b1;
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd1,
         128'hd4bf5d30e0b452aeb84111f11e2798e5, a0);
    in_valid = 1'b0;
    wait_drain();

    // All-zero input, in_ready low throughout SUB.
    send('0, 4'd2, {16{8'h63}}, a0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_int("in_ready_sub", int'(in_ready), 0);
      @(negedge clk);
    end
    wait_drain();

    // Backpressure with a second state waiting.
    va = 128'h00112233445566778899aabbccddeeff;
    vb = 128'hffeeddccbbaa99887766554433221100;
    ea = ref_ss(va);
    out_ready = 1'b0;
    send(va, 4'd5, ea, a0);
    in_data = vb;
    in_tag  = 4'd6;
    for (int i = 0; i < 8 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_int("bp_in_ready", int'(in_ready), 0);
      chk128("bp_hold_data", out_data, ea);
      chk_int("bp_hold_tag", int'(out_tag), 5);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(vb, 4'd6, ref_ss(vb), a1);
    chk_int("bp_same_edge", a1 - a0, 15);
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back with in_valid and out_ready held high.
    va = 128'h0123456789abcdeffedcba9876543210;
    vb = 128'h3243f6a8885a308d313198a2e0370734;
    vc = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    send(va, 4'd7, ref_ss(va), a0);
    send(vb, 4'd8, ref_ss(vb), a1);
    send(vc, 4'd9, ref_ss(vc), a2);
    in_valid = 1'b0;
    chk_int("b2b_gap01", a1 - a0, 5);
    chk_int("b2b_gap12", a2 - a1, 5);
    wait_drain();

    // Input noise during SUB.
    va = 128'hdeadbeefcafef00d0badc0de12345678;
    send(va, 4'd10, ref_ss(va), a0);
    for (int i = 0; i < 4; i++) begin
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_tag   = 4'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();

    // Reset while cnt==2, then a fresh state.
    va = 128'h11111111222222223333333344444444;
    send(va, 4'd12, ref_ss(va), a0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk_int("mid_rst_out_tag", int'(out_tag), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_int("post_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    vb = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;
    send(vb, 4'd3, ref_ss(vb), a1);
    in_valid = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
